mprj_io_cfg_sequencer: RTL and testbench

Management-side controller that holds per-pad configuration for the user project IO pads and shifts it into the daisy-chained GPIO control blocks. The control blocks drive the pad config lines: out-enable, input disable, drive mode and analog controls. The block is written through a simple register port, started by a request, and produces serial_clock, serial_data_out and serial_load. Once the chain is latched, the mprj pad configuration takes effect.

---
 rtl/mprj_io_cfg_sequencer_pkg.sv | 28 ++
 rtl/mprj_cfg_tick.sv | 29 ++
 rtl/mprj_io_cfg_sequencer.sv | 156 +++++++++++++++
 tb/tb_mprj_io_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_io_cfg_sequencer_pkg.sv
// rtl/mprj_io_cfg_sequencer_pkg.sv - shared constants, field offsets and FSM states for the IO config sequencer
package mprj_io_cfg_sequencer_pkg;

    localparam int CFG_BITS = 13;
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403;

    // Bit positions of the pad controls inside one configuration word
    localparam int CFG_MGMT_EN     = 0;
    localparam int CFG_OEB         = 1;
    localparam int CFG_HOLD        = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW_SEL    = 8;
    localparam int CFG_VTRIP_SEL   = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_MSB      = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mprj_cfg_tick.sv
// rtl/mprj_cfg_tick.sv - CLK_DIV phase counter producing a phase_end pulse
module mprj_cfg_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign phase_end = enable && (cnt == LAST);

    // Count cycles within a phase; idle at zero so each enabled run starts a fresh phase
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!enable || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mprj_io_cfg_sequencer.sv
// rtl/mprj_io_cfg_sequencer.sv - shadow pad config and serial shift/load into the GPIO control chain (optional MPRJ_CFG_AUTOLOAD_EN)
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module mprj_io_cfg_sequencer
    import mprj_io_cfg_sequencer_pkg::*;
#(
    parameter int NUM_PADS = `MPRJ_IO_PADS,
    parameter int CLK_DIV  = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    output logic                cfg_ready,
    input  logic                xfer_start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load
);

    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int BW = $clog2(CFG_BITS);
    localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(CFG_BITS - 1);

    seq_state_t          state, state_next;
    logic                phase, phase_next;
    logic [AW-1:0]       pad_cnt, pad_next;
    logic [BW-1:0]       bit_idx, bit_next;
    logic                phase_end;
    logic                tick_en;
    logic                start_req;
    logic                autoload_pending;
    logic                addr_ok;
    logic [AW-1:0]       addr_idx;
    logic [CFG_BITS-1:0] shadow [NUM_PADS];

    assign addr_ok   = ({1'b0, cfg_addr} < 7'(NUM_PADS));
    assign addr_idx  = cfg_addr[AW-1:0];
    assign cfg_rdata = addr_ok ? shadow[addr_idx] : '0;

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = ~busy;
    assign done      = (state == ST_DONE);
    assign tick_en   = (state == ST_SHIFT) || (state == ST_LOAD);

    // Outputs decode straight from state so an asserted reset clears them at once
    assign serial_clock    = (state == ST_SHIFT) && phase;
    assign serial_load     = (state == ST_LOAD);
    assign serial_data_out = (state == ST_SHIFT) ? shadow[pad_cnt][bit_idx] : 1'b0;

`ifdef MPRJ_CFG_AUTOLOAD_EN
    // Request one transfer of the reset defaults on the first edge out of reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            autoload_pending <= 1'b1;
        end else begin
            autoload_pending <= 1'b0;
        end
    end
`else
    assign autoload_pending = 1'b0;
`endif

    assign start_req = xfer_start | autoload_pending;

    mprj_cfg_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (tick_en),
        .phase_end(phase_end)
    );

    // Shadow words; writes are blocked while busy so SHIFT can read them live
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow[i] <= CFG_DEFAULT;
            end
        end else if (cfg_we && !busy && addr_ok) begin
            shadow[addr_idx] <= cfg_wdata;
        end
    end

    // FSM and shift position registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            pad_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            pad_cnt <= pad_next;
            bit_idx <= bit_next;
        end
    end

    // Next state: walk pads from the last down to 0, each word MSB first, low then high phase per bit
    always_comb begin
        state_next = state;
        phase_next = phase;
        pad_next   = pad_cnt;
        bit_next   = bit_idx;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_SHIFT;
                    phase_next = 1'b0;
                    pad_next   = PAD_LAST;
                    bit_next   = BIT_MSB;
                end
            end
            ST_SHIFT: begin
                if (phase_end) begin
                    if (!phase) begin
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        if (bit_idx == '0) begin
                            if (pad_cnt == '0) begin
                                state_next = ST_LOAD;
                            end else begin
                                pad_next = pad_cnt - AW'(1);
                                bit_next = BIT_MSB;
                            end
                        end else begin
                            bit_next = bit_idx - BW'(1);
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (phase_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// tb/tb_mprj_io_cfg_sequencer.sv - self-checking bench for mprj_io_cfg_sequencer
module tb_mprj_io_cfg_sequencer;

    localparam int NP       = 4;
    localparam int CD       = 2;
    localparam int CB       = 13;
    localparam int TOTAL    = NP * CB;
    localparam int EXP_BUSY = 2 * CD * TOTAL + CD + 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          cfg_we;
    logic [5:0]    cfg_addr;
    logic [CB-1:0] cfg_wdata;
    logic [CB-1:0] cfg_rdata;
    logic          cfg_ready;
    logic          xfer_start;
    logic          busy;
    logic          done;
    logic          serial_clock;
    logic          serial_data_out;
    logic          serial_load;

    mprj_io_cfg_sequencer #(
        .NUM_PADS(NP),
        .CLK_DIV (CD)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .cfg_ready      (cfg_ready),
        .xfer_start     (xfer_start),
        .busy           (busy),
        .done           (done),
        .serial_clock   (serial_clock),
        .serial_data_out(serial_data_out),
        .serial_load    (serial_load)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard and chain model
    logic          exp_q[$];
    logic [CB-1:0] mdl [NP];
    logic [TOTAL-1:0] chain_sr;
    logic [CB-1:0] chain_pad [NP];
    logic          prev_sclk, prev_load, e;
    int            load_len, busy_len, sclk_rises = 0, done_seen = 0, loads = 0;
    int            xfer_r0, load0;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_sclk = 1'b0;
            prev_load = 1'b0;
            load_len  = 0;
            busy_len  = 0;
        end else begin
            check("sclk_load_overlap", int'(serial_clock & serial_load), 0);
            if (serial_clock && !prev_sclk) begin
                sclk_rises++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("serial_bit", int'(serial_data_out), int'(e));
                end
                chain_sr = {chain_sr[TOTAL-2:0], serial_data_out};
            end
            if (serial_load) load_len++;
            if (!serial_load && prev_load) begin
                check("load_len", load_len, CD);
                for (int p = 0; p < NP; p++) chain_pad[p] = chain_sr[p*CB +: CB];
                loads++;
                load_len = 0;
            end
            if (busy) busy_len++;
            if (done) begin
                done_seen++;
                check("done_cycle", busy_len, EXP_BUSY);
            end
            if (!busy) busy_len = 0;
            prev_sclk = serial_clock;
            prev_load = serial_load;
        end
    end

    task automatic push_expected();
        for (int p = NP - 1; p >= 0; p--)
            for (int b = CB - 1; b >= 0; b--)
                exp_q.push_back(mdl[p][b]);
        xfer_r0 = sclk_rises;
        load0   = loads;
    endtask

    task automatic start_xfer();
        push_expected();
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", int'(done_seen != d0), 1);
    endtask

    task automatic xfer_check(input string tag);
        tick();
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_rises"}, sclk_rises - xfer_r0, TOTAL);
        check({tag, "_loads"}, loads - load0, 1);
        for (int p = 0; p < NP; p++)
            check($sformatf("%s_pad%0d", tag, p), int'(chain_pad[p]), int'(mdl[p]));
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [CB-1:0] exp);
        cfg_addr = a;
        #1;
        check(name, int'(cfg_rdata), int'(exp));
    endtask

    task automatic after_release();
`ifdef MPRJ_CFG_AUTOLOAD_EN
        push_expected();
        tick();
        check("autoload_busy", int'(busy), 1);
        wait_done(1000);
        xfer_check("autoload");
`else
        int d0 = done_seen;
        int hi = 0;
        repeat (500) begin
            tick();
            if (busy) hi++;
        end
        check("idle_500_busy", hi, 0);
        check("idle_500_done", done_seen - d0, 0);
`endif
    endtask

    typedef struct {
        logic          we;
        logic [5:0]    addr;
        logic [CB-1:0] wdata;
        logic [CB-1:0] exp_rdata;
    } vec_t;

    vec_t vec [8];

    initial begin
        int n;
        int d0;

        vec[0] = '{1'b0, 6'd0,  13'h0000, 13'h0403};
        vec[1] = '{1'b0, 6'd3,  13'h0000, 13'h0403};
        vec[2] = '{1'b1, 6'd1,  13'h1FFF, 13'h1FFF};
        vec[3] = '{1'b1, 6'd2,  13'h0000, 13'h0000};
        vec[4] = '{1'b1, 6'd60, 13'h1234, 13'h0000};
        vec[5] = '{1'b0, 6'd4,  13'h0000, 13'h0000};
        vec[6] = '{1'b0, 6'd1,  13'h0000, 13'h1FFF};
        vec[7] = '{1'b0, 6'd0,  13'h0000, 13'h0403};

        for (int p = 0; p < NP; p++) mdl[p] = 13'h0403;

        resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; xfer_start = 1'b0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sclk", int'(serial_clock), 0);
        check("rst_sdo", int'(serial_data_out), 0);
        check("rst_load", int'(serial_load), 0);
        check("rst_ready", int'(cfg_ready), 1);
        resetn = 1'b1;
        after_release();

        // Transfer of all defaults
        start_xfer();
        wait_done(1000);
        xfer_check("dflt");

        // Register table
        for (int i = 0; i < 8; i++) begin
            cfg_we = vec[i].we; cfg_addr = vec[i].addr; cfg_wdata = vec[i].wdata;
            tick();
            cfg_we = 1'b0;
            check($sformatf("vec%0d_rdata", i), int'(cfg_rdata), int'(vec[i].exp_rdata));
        end
        mdl[1] = 13'h1FFF;
        mdl[2] = 13'h0000;

        // Transfer with edited words, blocked write and ignored restart mid-flight
        d0 = done_seen;
        start_xfer();
        repeat (10) tick();
        check("busy_ready", int'(cfg_ready), 0);
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 13'h0AAA;
        tick();
        cfg_we = 1'b0;
        read_check("busy_write_blocked", 6'd0, 13'h0403);
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        wait_done(1000);
        xfer_check("edit");
        repeat (50) tick();
        check("single_done", done_seen - d0, 1);
        check("no_restart", int'(busy), 0);
        read_check("rdata_pad1", 6'd1, 13'h1FFF);

        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 13'h0AAA;
        tick();
        cfg_we = 1'b0;
        read_check("idle_write_ok", 6'd0, 13'h0AAA);
        mdl[0] = 13'h0AAA;

        // Reset during bit 20 of the shift
        d0 = done_seen;
        start_xfer();
        n = 0;
        while ((sclk_rises - xfer_r0) < 21 && n < 400) begin
            tick();
            n++;
        end
        check("reached_bit20", int'((sclk_rises - xfer_r0) >= 21), 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_sclk", int'(serial_clock), 0);
        check("mid_rst_sdo", int'(serial_data_out), 0);
        check("mid_rst_load", int'(serial_load), 0);
        check("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        for (int p = 0; p < NP; p++) mdl[p] = 13'h0403;
        for (int p = 0; p < NP; p++)
            read_check($sformatf("post_rst_pad%0d", p), 6'(p), 13'h0403);
`ifndef MPRJ_CFG_AUTOLOAD_EN
        check("mid_rst_no_done", done_seen - d0, 0);
`endif
        after_release();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
